if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction fetch stage plus IF/ID pipeline register; sits directly upstream of the decode stage.
//  Owns the fetch PC and issues requests to instruction memory over a req/ready handshake.
//  Presents {PC, instruction, valid} to decode, honouring hazard freeze and branch redirect.
//  Inserts a NOP bubble whenever no valid instruction is available.
// PARAMETERS
//  RESET_PC   32'h0000_0000  fetch address after reset
//  NOP_INSTR  32'hF000_0000  bubble word; cond=NV, so decode zeroes all control signals
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  rst            in   1   synchronous, active-high reset
//  freeze         in   1   hazard stall from decode; holds the IF/ID register and blocks PC advance
//  branch_taken   in   1   redirect request; wins over freeze
//  branch_address in   32  redirect target; bits [1:0] forced to 0
//  imem_req       out  1   fetch request to instruction memory
//  imem_addr      out  32  fetch address; bits [1:0] always 0
//  imem_rdata     in   32  instruction word; valid only when imem_ready=1
//  imem_ready     in   1   data return; may be high in the first req cycle (zero-wait memory)
//  PC             out  32  fetch address + 4 of the presented instruction, to decode
//  instruction    out  32  instruction word to decode
//  valid          out  1   1 = instruction is real; 0 = NOP_INSTR bubble
// BEHAVIOUR
//  Reset (sync): pc=RESET_PC; state=FETCH; PC=0; instruction=NOP_INSTR; valid=0; buffers cleared.
//   imem_req is 0 in the reset cycle and 1 from the first cycle after it.
//  Memory rules: while imem_req=1, imem_addr is held stable until a cycle with imem_ready=1.
//   A request is never withdrawn or retargeted while outstanding.
//  FSM states and transitions, evaluated in priority order within each state:
//   FETCH (imem_req=1, imem_addr=pc)
//    ready & branch_taken: discard word; pc<=branch_address; stay in FETCH.
//    ready & freeze: store word in hold_buf; pc<=pc+4; go to HOLD; IF/ID unchanged.
//    ready (neither): IF/ID<={pc+4, rdata, 1}; pc<=pc+4; stay in FETCH.
//    !ready & branch_taken: target_buf<=branch_address; go to REDIRECT.
//    !ready otherwise: keep requesting pc.
//   HOLD (imem_req=0)
//    branch_taken: discard hold_buf; pc<=branch_address; go to FETCH.
//    !freeze: IF/ID<={hold_pc+4, hold_buf, 1}; go to FETCH.
//    freeze: stay in HOLD.
//   REDIRECT (imem_req=1 on the old address)
//    branch_taken: target_buf<=newest branch_address.
//    ready: discard word; pc<=target_buf (or the same-cycle branch_address); go to FETCH.
//  IF/ID register update rules, in priority order:
//   branch_taken=1: load {0, NOP_INSTR, 0}, even if freeze=1.
//   else freeze=1: hold the register.
//   else: load the instruction selected above, or a bubble {0, NOP_INSTR, 0} if none.
//  Latency: with zero-wait memory and no stalls, one instruction per cycle.
//   The word for address A appears at IF/ID one cycle after its request is accepted.
//  Arithmetic: pc+4 is 32-bit and wraps modulo 2^32 (0xFFFF_FFFC+4 = 0).
//  rst asserted mid-transaction: abandon any request, clear all buffers, restart at RESET_PC.
//   Memory must tolerate the abandoned request.
// TESTING
//  T1 Reset, zero-wait memory returning word=addr: cycle1 IF/ID={4, 0x0, 1}; then
//     {8, 0x4, 1}, {12, 0x8, 1}, ... one per cycle.
//  T2 Two wait states per fetch: imem_addr held for 3 cycles; IF/ID shows valid=0 bubbles
//     between real words; no address is skipped or repeated.
//  T3 freeze high for 3 cycles while ready arrives: IF/ID held unchanged; word buffered; on
//     release, the next instruction appears once with correct PC and no duplicates.
//  T4 branch_taken with target 0x100 while a request to 0x20 is pending: 0x20 stays stable until
//     ready; that word is discarded; next request is 0x100; IF/ID is a bubble meanwhile.
//  T5 branch_taken with freeze=1 in HOLD: IF/ID flushed to NOP, valid=0; hold_buf dropped;
//     fetch resumes at target; target 0x103 yields imem_addr=0x100.
//  T6 rst pulsed during a wait-state fetch: next cycle imem_req=0, valid=0; fetch resumes at
//     RESET_PC; PC wrap 0xFFFF_FFFC -> PC output 0x0000_0000.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Issues requests to instruction memory, buffers words across decode stalls, and follows branch redirects.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] PC,
    output logic [31:0] instruction,
    output logic        valid
);

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        HOLD     = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] hold_buf;
    logic [31:0] target_buf;

    logic [31:0] pc_plus4;
    logic [31:0] branch_tgt;
    logic        accept;
    logic        word_ok;
    logic [31:0] word_pc;
    logic [31:0] word_data;

    assign imem_addr  = {pc[31:2], 2'b00};
    assign pc_plus4   = imem_addr + 32'd4;
    assign branch_tgt = {branch_address[31:2], 2'b00};
    assign accept     = imem_req && imem_ready;

    // A word is ready for decode either straight from memory or from the stall buffer;
    // in HOLD the pc has already advanced, so it equals the buffered word's address + 4.
    always_comb begin
        word_ok   = 1'b0;
        word_pc   = pc_plus4;
        word_data = imem_rdata;
        if (state == FETCH && accept) begin
            word_ok = 1'b1;
        end else if (state == HOLD) begin
            word_ok   = 1'b1;
            word_pc   = imem_addr;
            word_data = hold_buf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            hold_buf    <= 32'd0;
            target_buf  <= 32'd0;
            imem_req    <= 1'b0;
            PC          <= 32'd0;
            instruction <= NOP_INSTR;
            valid       <= 1'b0;
        end else begin
            imem_req <= 1'b1;
            case (state)
                FETCH: begin
                    if (branch_taken) begin
                        // An outstanding request cannot be retargeted, so park the target.
                        if (imem_req && !imem_ready) begin
                            target_buf <= branch_tgt;
                            state      <= REDIRECT;
                        end else begin
                            pc <= branch_tgt;
                        end
                    end else if (accept) begin
                        pc <= pc_plus4;
                        if (freeze) begin
                            hold_buf <= imem_rdata;
                            state    <= HOLD;
                            imem_req <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        pc    <= branch_tgt;
                        state <= FETCH;
                    end else if (!freeze) begin
                        state <= FETCH;
                    end else begin
                        imem_req <= 1'b0;
                    end
                end
                REDIRECT: begin
                    if (imem_ready) begin
                        pc    <= branch_taken ? branch_tgt : target_buf;
                        state <= FETCH;
                    end else if (branch_taken) begin
                        target_buf <= branch_tgt;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase

            if (branch_taken) begin
                PC          <= 32'd0;
                instruction <= NOP_INSTR;
                valid       <= 1'b0;
            end else if (!freeze) begin
                PC          <= word_ok ? word_pc : 32'd0;
                instruction <= word_ok ? word_data : NOP_INSTR;
                valid       <= word_ok;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage: transaction-level reference model plus directed literal checks.
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'hF000_0000;

    logic        clk = 1'b0;
    logic        rst, freeze, branch_taken, imem_ready, imem_req, valid;
    logic [31:0] branch_address, imem_rdata, imem_addr, PC, instruction;

    if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_address(branch_address), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .PC(PC),
        .instruction(instruction), .valid(valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] salt = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending request address, parked redirect target, stalled word, decode view.
    bit          m_live = 1'b0;
    bit          m_req, m_redir, m_hold, have, acc;
    logic [31:0] m_pc, m_tgt, m_word, ba, hp, hw;
    logic [31:0] e_pc, e_ins;
    bit          e_v;

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1'b1; m_req = 1'b0; m_pc = RST_PC; m_redir = 1'b0; m_hold = 1'b0;
            e_pc = 32'd0; e_ins = NOP; e_v = 1'b0;
        end else if (m_live) begin
            acc  = m_req && imem_ready;
            ba   = branch_address & 32'hFFFF_FFFC;
            have = 1'b0; hp = 32'd0; hw = 32'd0;
            if (m_hold) begin
                if (branch_taken) begin
                    m_hold = 1'b0; m_pc = ba;
                end else if (!freeze) begin
                    have = 1'b1; hp = m_pc; hw = m_word; m_hold = 1'b0;
                end
            end else if (m_redir) begin
                if (branch_taken) m_tgt = ba;
                if (acc) begin m_pc = m_tgt; m_redir = 1'b0; end
            end else if (branch_taken) begin
                if (acc || !m_req) m_pc = ba;
                else begin m_redir = 1'b1; m_tgt = ba; end
            end else if (acc) begin
                if (freeze) begin m_hold = 1'b1; m_word = m_pc ^ salt; end
                else begin have = 1'b1; hp = m_pc + 32'd4; hw = m_pc ^ salt; end
                m_pc = m_pc + 32'd4;
            end
            if (branch_taken) begin
                e_pc = 32'd0; e_ins = NOP; e_v = 1'b0;
            end else if (!freeze) begin
                e_pc = have ? hp : 32'd0; e_ins = have ? hw : NOP; e_v = have;
            end
            m_req = !m_hold;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_req", 32'(imem_req), 32'(m_req));
            if (m_req) chk("model_addr", imem_addr, m_pc);
            chk("model_pc", PC, e_pc);
            chk("model_instr", instruction, e_ins);
            chk("model_valid", 32'(valid), 32'(e_v));
        end
    end

    // Memory returns addr ^ salt when ready, garbage otherwise.
    task automatic cyc(input bit r, input bit f, input bit b, input logic [31:0] a, input bit rdy);
        rst = r; freeze = f; branch_taken = b; branch_address = a; imem_ready = rdy;
        imem_rdata = rdy ? (imem_addr ^ salt) : $urandom;
        @(negedge clk);
    endtask

    task automatic chk_ifid(input string name, input logic [31:0] p, input logic [31:0] i, input bit v);
        chk({name, "_pc"}, PC, p);
        chk({name, "_instr"}, instruction, i);
        chk({name, "_valid"}, 32'(valid), 32'(v));
    endtask

    initial begin
        imem_rdata = 32'd0;
        // T1: reset and zero-wait streaming
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk_ifid("rst", 32'd0, NOP, 0);
        cyc(0, 0, 0, 0, 1);
        chk("t1_req", 32'(imem_req), 32'd1);
        chk("t1_addr0", imem_addr, 32'd0);
        cyc(0, 0, 0, 0, 1);
        chk_ifid("t1_w0", 32'd4, 32'd0, 1);
        cyc(0, 0, 0, 0, 1);
        chk_ifid("t1_w1", 32'd8, 32'd4, 1);
        // T2: two wait states
        cyc(0, 0, 0, 0, 0);
        chk_ifid("t2_bub", 32'd0, NOP, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t2_addr_held", imem_addr, 32'd8);
        cyc(0, 0, 0, 0, 1);
        chk_ifid("t2_w", 32'd12, 32'd8, 1);
        // T3: freeze while a word arrives
        cyc(0, 1, 0, 0, 1);
        chk_ifid("t3_hold", 32'd12, 32'd8, 1);
        chk("t3_req_off", 32'(imem_req), 32'd0);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        chk_ifid("t3_hold2", 32'd12, 32'd8, 1);
        cyc(0, 0, 0, 0, 1);
        chk_ifid("t3_rel", 32'd16, 32'd12, 1);
        chk("t3_next_addr", imem_addr, 32'd16);
        cyc(0, 0, 0, 0, 1);
        chk_ifid("t3_after", 32'd20, 32'd16, 1);
        // T4: redirect while a request to 0x20 is outstanding
        cyc(0, 0, 1, 32'h20, 1);
        chk("t4_addr20", imem_addr, 32'h20);
        cyc(0, 0, 1, 32'h100, 0);
        chk("t4_stable", imem_addr, 32'h20);
        chk_ifid("t4_bub", 32'd0, NOP, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t4_stable2", imem_addr, 32'h20);
        cyc(0, 0, 0, 0, 1);
        chk("t4_tgt", imem_addr, 32'h100);
        chk_ifid("t4_disc", 32'd0, NOP, 0);
        cyc(0, 0, 0, 0, 1);
        chk_ifid("t4_w", 32'h104, 32'h100, 1);
        // T5: branch during HOLD with freeze, unaligned target
        cyc(0, 1, 0, 0, 1);
        chk("t5_hold_req", 32'(imem_req), 32'd0);
        cyc(0, 1, 1, 32'h103, 0);
        chk_ifid("t5_flush", 32'd0, NOP, 0);
        chk("t5_addr", imem_addr, 32'h100);
        cyc(0, 0, 0, 0, 1);
        chk_ifid("t5_w", 32'h104, 32'h100, 1);
        // PC wrap
        cyc(0, 0, 1, 32'hFFFF_FFFC, 1);
        cyc(0, 0, 0, 0, 1);
        chk_ifid("wrap", 32'd0, 32'hFFFF_FFFC, 1);
        chk("wrap_addr", imem_addr, 32'd0);
        // T6: reset during a wait-state fetch
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("t6_req", 32'(imem_req), 32'd0);
        chk("t6_valid", 32'(valid), 32'd0);
        cyc(0, 0, 0, 0, 1);
        chk("t6_resume", imem_addr, RST_PC);
        chk("t6_req_on", 32'(imem_req), 32'd1);

        // Random traffic checked by the model
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] a;
            if (i % 500 == 0) salt = $urandom;
            a = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cyc($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 20,
                $urandom_range(0, 99) < 8, a, $urandom_range(0, 99) < 60);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
